// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and widths for the pipeline hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Register index width and stall-counter width used across the slice
    localparam int REG_IDX_W   = 3;
    localparam int STALL_CNT_W = 16;

    // Hazard controller states: normal flow, or front end frozen by a mul/div
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Width-parameterised up-counter with increment enable that
//                sticks at all-ones instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding at the maximum value once reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Detects load-use hazards, squashes
//                on taken branches and, when HAZARD_MULDIV_EN is defined,
//                freezes the front end for a multi-cycle multiply/divide.
//                Counts stalled cycles in a saturating 16-bit counter.
//  Config      : `define HAZARD_MULDIV_EN to enable the mul/div busy FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
`ifdef HAZARD_MULDIV_EN
#(
    parameter int MULDIV_CYCLES = 4
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_IDX_W-1:0]   rs_ID,
    input  logic [REG_IDX_W-1:0]   rt_ID,
    input  logic                   use_rs_ID,
    input  logic                   use_rt_ID,
    input  logic [REG_IDX_W-1:0]   rt_EX,
    input  logic                   mem_read_EX,
    input  logic                   branch_taken_EX,
    input  logic                   muldiv_start_EX,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_mm_bubble,
    output logic                   muldiv_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic w_luh;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_ex_mm_bubble;
    logic w_muldiv_done;

    assign w_luh = mem_read_EX & ((use_rs_ID & (rs_ID == rt_EX)) |
                                  (use_rt_ID & (rt_ID == rt_EX)));

`ifdef HAZARD_MULDIV_EN
    // The start cycle is the first stall cycle, so BUSY lasts MULDIV_CYCLES-1
    localparam logic [3:0] c_BUSY_LOAD = 4'(MULDIV_CYCLES - 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_busy_cnt;
    logic [3:0] w_busy_cnt_nxt;

    // State and busy down-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_busy_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end
`else
    logic w_unused_muldiv;
    assign w_unused_muldiv = muldiv_start_EX;
`endif

    // Next-state and stage control decode; reset leaves every stage flowing
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_mm_bubble = 1'b0;
        w_muldiv_done  = 1'b0;
`ifdef HAZARD_MULDIV_EN
        w_state_nxt    = r_state;
        w_busy_cnt_nxt = r_busy_cnt;
`endif
        if (rst) begin
`ifdef HAZARD_MULDIV_EN
            if (r_state == BUSY) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_write  = 1'b0;
                w_ex_mm_bubble = 1'b1;
                if (r_busy_cnt == 4'd0) begin
                    w_muldiv_done = 1'b1;
                    w_state_nxt   = RUN;
                end else begin
                    w_busy_cnt_nxt = r_busy_cnt - 4'd1;
                end
            end else if (branch_taken_EX) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (muldiv_start_EX) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_write  = 1'b0;
                w_ex_mm_bubble = 1'b1;
                w_state_nxt    = BUSY;
                w_busy_cnt_nxt = c_BUSY_LOAD;
            end else if (w_luh) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
`else
            if (branch_taken_EX) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_luh) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
`endif
        end
    end

    assign pc_write     = w_pc_write;
    assign if_id_write  = w_if_id_write;
    assign id_ex_write  = w_id_ex_write;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_bubble = w_id_ex_bubble;
`ifdef HAZARD_MULDIV_EN
    assign ex_mm_bubble = w_ex_mm_bubble;
    assign muldiv_done  = w_muldiv_done;
`else
    logic w_unused_busy;
    assign w_unused_busy = w_ex_mm_bubble | w_muldiv_done;
    assign ex_mm_bubble  = 1'b0;
    assign muldiv_done   = 1'b0;
`endif

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc_en (~w_pc_write),
        .o_count  (stall_cnt)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl. The driver pushes the
//                expected outputs of every cycle; the monitor pops and
//                compares on the falling edge.
//  Config      : honours HAZARD_MULDIV_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
    localparam int MD_EN = 1;
`else
    localparam int MD_EN = 0;
`endif
    localparam int MD_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  rs_ID = '0, rt_ID = '0, rt_EX = '0;
    logic        use_rs_ID = 1'b0, use_rt_ID = 1'b0;
    logic        mem_read_EX = 1'b0, branch_taken_EX = 1'b0, muldiv_start_EX = 1'b0;
    logic        pc_write, if_id_write, id_ex_write;
    logic        if_id_flush, id_ex_bubble, ex_mm_bubble, muldiv_done;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

`ifdef HAZARD_MULDIV_EN
    hazard_ctrl #(.MULDIV_CYCLES(MD_CYC)) dut (
`else
    hazard_ctrl dut (
`endif
        .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .rt_EX(rt_EX),
        .mem_read_EX(mem_read_EX), .branch_taken_EX(branch_taken_EX),
        .muldiv_start_EX(muldiv_start_EX), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mm_bubble(ex_mm_bubble), .muldiv_done(muldiv_done),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        string       tag;
        logic [22:0] val;   // {pc,ifid,idex,flush,idbub,exbub,done,stall_cnt}
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: stalled-cycle total and remaining mul/div stalls
    int   m_cnt = 0;
    int   m_rem = 0;

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [22:0] act;
            e   = q.pop_front();
            act = {pc_write, if_id_write, id_ex_write, if_id_flush,
                   id_ex_bubble, ex_mm_bubble, muldiv_done, stall_cnt};
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h",
                         e.tag, act[22:16], act[15:0], e.val[22:16], e.val[15:0]);
            end
        end
    end

    // Drive one cycle, predict its outputs, then advance past the next edge
    task automatic step(input string tag, input logic r, input logic [2:0] rs,
                        input logic [2:0] rt, input logic urs, input logic urt,
                        input logic [2:0] rtx, input logic mr, input logic br,
                        input logic md);
        logic pc, ifid, idex, fl, idb, exb, dn;
        logic luh;
        exp_t e;
        rst = r; rs_ID = rs; rt_ID = rt; use_rs_ID = urs; use_rt_ID = urt;
        rt_EX = rtx; mem_read_EX = mr; branch_taken_EX = br; muldiv_start_EX = md;
        pc = 1; ifid = 1; idex = 1; fl = 0; idb = 0; exb = 0; dn = 0;
        luh = mr && ((urs && rs == rtx) || (urt && rt == rtx));
        if (!r) begin
            m_cnt = 0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            pc = 0; ifid = 0; idex = 0; exb = 1;
            dn = (m_rem == 1);
            m_rem--;
        end else if (br) begin
            fl = 1; idb = 1;
        end else if (MD_EN != 0 && md) begin
            pc = 0; ifid = 0; idex = 0; exb = 1;
            m_rem = MD_CYC - 1;
        end else if (luh) begin
            pc = 0; ifid = 0; idb = 1;
        end
        e.tag = tag;
        e.val = {pc, ifid, idex, fl, idb, exb, dn, 16'(m_cnt)};
        q.push_back(e);
        if (r && !pc && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state, including ignoring a hazard while held in reset
        step("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("reset_luh", 1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
        idle("after_reset");
        // Load-use single stall, then count visible
        step("luh", 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        idle("luh_count");
        step("luh_rt", 1'b1, 3'd1, 3'd6, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        // Operand not read: no stall
        step("unused_rs", 1'b1, 3'd3, 3'd5, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        step("no_load", 1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        // Branch overrides load-use and mul/div start
        step("br_luh", 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        step("br_md", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        idle("after_br");
`ifdef HAZARD_MULDIV_EN
        // Full mul/div with events ignored while busy
        step("md_start", 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
        step("md_busy1", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step("md_busy2", 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
        idle("md_done");
        idle("md_after");
        // Reset in the second busy cycle abandons the operation
        step("md2_start", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        idle("md2_busy1");
        step("md2_rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        idle("md2_after");
        idle("md2_after2");
`endif
        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 39) != 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        end
        // Saturation: 65534 stalls preload 16'hFFFE, three more must stick
        step("sat_reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            step("sat_fill", 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step("sat_more", 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        end
        idle("sat_hold");
        idle("sat_hold2");
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
